// File: rtl/decode_queue.sv
// Decode-on-entry instruction queue: LEGv8-subset decode into a DEPTH-entry FIFO, one-cycle push-to-head latency.
// Backpressure: in_ready drops when full, during flush and in reset; there is no write-through when full.
module decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [XLEN-1:0]  out_imm12,
  output logic [XLEN-1:0]  out_imm26,
  output logic [XLEN-1:0]  out_imm19,
  output logic [XLEN-1:0]  out_imm9,
  output logic [5:0]       out_shamt,
  output logic [4:0]       out_rm,
  output logic [4:0]       out_rn,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ADDS = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;
  localparam logic [3:0] OP_CBZ  = 4'd5;
  localparam logic [3:0] OP_LDUR = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_STUR = 4'd10;
  localparam logic [3:0] OP_SUBS = 4'd11;
  localparam logic [3:0] OP_INV  = 4'd12;
  localparam logic [3:0] OP_CBNZ = 4'd13;
  localparam logic [3:0] OP_SUBI = 4'd14;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]      opcode;
    logic [XLEN-1:0] imm12;
    logic [XLEN-1:0] imm26;
    logic [XLEN-1:0] imm19;
    logic [XLEN-1:0] imm9;
    logic [5:0]      shamt;
    logic [4:0]      rm;
    logic [4:0]      rn;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
  } bundle_t;

  bundle_t       dec;
  bundle_t       head;
  bundle_t       mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    dec        = '0;
    dec.imm12  = XLEN'(in_inst[21:10]);
    dec.imm26  = XLEN'($signed(in_inst[25:0]));
    dec.imm19  = XLEN'($signed(in_inst[23:5]));
    dec.imm9   = XLEN'($signed(in_inst[20:12]));
    dec.shamt  = in_inst[15:10];
    dec.rm     = in_inst[20:16];
    dec.rn     = in_inst[9:5];
    dec.rd     = in_inst[4:0];
    dec.pc     = in_pc;
    if (in_inst[31:26] == 6'h05)                            dec.opcode = OP_B;
    else if (in_inst[31:24] == 8'hB4)                       dec.opcode = OP_CBZ;
    else if (in_inst[31:24] == 8'hB5)                       dec.opcode = OP_CBNZ;
    else if (in_inst[31:24] == 8'h54 && in_inst[4:0] == 5'h0B) dec.opcode = OP_BLT;
    else if (in_inst[31:22] == 10'h244)                     dec.opcode = OP_ADDI;
    else if (in_inst[31:22] == 10'h344)                     dec.opcode = OP_SUBI;
    else begin
      case (in_inst[31:21])
        11'h69A: dec.opcode = OP_LSR;
        11'h69B: dec.opcode = OP_LSL;
        11'h758: dec.opcode = OP_SUBS;
        11'h7C0: dec.opcode = OP_STUR;
        11'h7C2: dec.opcode = OP_LDUR;
        11'h558: dec.opcode = OP_ADDS;
        // MUL is only well-formed with the fixed 0x1F field; anything else is silently illegal
        11'h4D8: dec.opcode = (in_inst[15:10] == 6'h1F) ? OP_MUL : OP_INV;
        default: dec.opcode = OP_INV;
      endcase
    end
  end

  assign in_ready  = reset_n && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp] <= dec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= ptr_next(wp);
      if (pop)  rp <= ptr_next(rp);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_cnt <= '0;
    end else if (push && dec.opcode == OP_INV && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign head        = mem[rp];
  assign out_opcode  = head.opcode;
  assign out_imm12   = head.imm12;
  assign out_imm26   = head.imm26;
  assign out_imm19   = head.imm19;
  assign out_imm9    = head.imm9;
  assign out_shamt   = head.shamt;
  assign out_rm      = head.rm;
  assign out_rn      = head.rn;
  assign out_rd      = head.rd;
  assign out_pc      = head.pc;
  assign out_illegal = (head.opcode == OP_INV);
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vectors, backpressure, flush, counter saturation and reset.
module tb_decode_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_opcode;
  logic [XLEN-1:0]  out_imm12, out_imm26, out_imm19, out_imm9, out_pc;
  logic [5:0]       out_shamt;
  logic [4:0]       out_rm, out_rn, out_rd;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int passed = 0;
  int total  = 0;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_imm12(out_imm12), .out_imm26(out_imm26), .out_imm19(out_imm19), .out_imm9(out_imm9),
    .out_shamt(out_shamt), .out_rm(out_rm), .out_rn(out_rn), .out_rd(out_rd),
    .out_pc(out_pc), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", in_ready); else passed++;
    total++; if (illegal_cnt !== 2'd0) $display("FAIL rst_cnt got=%0d exp=0", illegal_cnt); else passed++;
    total++; if (out_opcode !== 4'd0) $display("FAIL rst_opcode got=%0d exp=0", out_opcode); else passed++;
    total++; if (out_pc !== 64'd0) $display("FAIL rst_pc got=%h exp=0", out_pc); else passed++;
    reset_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); else passed++;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    push1(32'h9100_1441, 64'h100);
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%0b exp=1", out_valid); else passed++;
    total++; if (out_opcode !== 4'd1) $display("FAIL addi_opcode got=%0d exp=1", out_opcode); else passed++;
    total++; if (out_imm12 !== 64'd5) $display("FAIL addi_imm12 got=%h exp=5", out_imm12); else passed++;
    total++; if (out_rn !== 5'd2) $display("FAIL addi_rn got=%0d exp=2", out_rn); else passed++;
    total++; if (out_rd !== 5'd1) $display("FAIL addi_rd got=%0d exp=1", out_rd); else passed++;
    total++; if (out_pc !== 64'h100) $display("FAIL addi_pc got=%h exp=100", out_pc); else passed++;
    total++; if (out_illegal !== 1'b0) $display("FAIL addi_illegal got=%0b exp=0", out_illegal); else passed++;
  endtask

  task automatic test_sign_ext();
    push1(32'h17FF_FFFF, 64'h104);
    total++; if (out_opcode !== 4'd4) $display("FAIL b_opcode got=%0d exp=4", out_opcode); else passed++;
    total++; if (out_imm26 !== {64{1'b1}}) $display("FAIL b_imm26 got=%h exp=all-ones", out_imm26); else passed++;
    push1(32'hB400_0040, 64'h108);
    total++; if (out_opcode !== 4'd5) $display("FAIL cbz_opcode got=%0d exp=5", out_opcode); else passed++;
    total++; if (out_imm19 !== 64'd2) $display("FAIL cbz_imm19 got=%h exp=2", out_imm19); else passed++;
    push1(32'hB500_0040, 64'h10C);
    total++; if (out_opcode !== 4'd13) $display("FAIL cbnz_opcode got=%0d exp=13", out_opcode); else passed++;
    push1(32'hF85F_F000, 64'h110);
    total++; if (out_opcode !== 4'd6) $display("FAIL ldur_opcode got=%0d exp=6", out_opcode); else passed++;
    total++; if (out_imm9 !== {64{1'b1}}) $display("FAIL ldur_imm9 got=%h exp=all-ones", out_imm9); else passed++;
    push1(32'hD100_0421, 64'h114);
    total++; if (out_opcode !== 4'd14) $display("FAIL subi_opcode got=%0d exp=14", out_opcode); else passed++;
    total++; if (out_imm12 !== 64'd1) $display("FAIL subi_imm12 got=%h exp=1", out_imm12); else passed++;
  endtask

  task automatic test_mul();
    push1(32'h9B02_7C20, 64'h118);
    total++; if (out_opcode !== 4'd9) $display("FAIL mul_opcode got=%0d exp=9", out_opcode); else passed++;
    total++; if (out_rm !== 5'd2) $display("FAIL mul_rm got=%0d exp=2", out_rm); else passed++;
    total++; if (out_rn !== 5'd1) $display("FAIL mul_rn got=%0d exp=1", out_rn); else passed++;
    total++; if (out_rd !== 5'd0) $display("FAIL mul_rd got=%0d exp=0", out_rd); else passed++;
    total++; if (out_shamt !== 6'h1F) $display("FAIL mul_shamt got=%h exp=1f", out_shamt); else passed++;
    push1(32'h9B02_0020, 64'h11C);
    total++; if (out_opcode !== 4'd12) $display("FAIL badmul_opcode got=%0d exp=12", out_opcode); else passed++;
    total++; if (out_illegal !== 1'b1) $display("FAIL badmul_illegal got=%0b exp=1", out_illegal); else passed++;
    total++; if (illegal_cnt !== 2'd1) $display("FAIL badmul_cnt got=%0d exp=1", illegal_cnt); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mul_drain got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push1(32'h9100_1441, 64'h200);
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got=%0b exp=1", in_ready); else passed++;
    push1(32'h9100_1441, 64'h204);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got=%0b exp=0", in_ready); else passed++;
    in_valid = 1'b1; in_inst = 32'h9100_1441; in_pc = 64'h208;
    tick();
    total++; if (out_pc !== 64'h200) $display("FAIL bp_head_held got=%h exp=200", out_pc); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_still_full got=%0b exp=0", in_ready); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_pc !== 64'h204) $display("FAIL bp_second got=%h exp=204", out_pc); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got=%0b exp=1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_pc !== 64'h208) $display("FAIL bp_third got=%h exp=208", out_pc); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_third_valid got=%0b exp=1", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push1(32'h9100_1441, 64'h300);
    push1(32'h9100_1441, 64'h304);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0000; in_pc = 64'h308;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready_low got=%0b exp=0", in_ready); else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%0b exp=1", in_ready); else passed++;
    total++; if (illegal_cnt !== 2'd1) $display("FAIL flush_cnt got=%0d exp=1", illegal_cnt); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_not_stored got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push1(32'h0000_0000, 64'h400 + 64'(i * 4));
      total++;
      if (illegal_cnt !== exp_seq[i]) $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, illegal_cnt, exp_seq[i]);
      else passed++;
    end
    in_valid = 1'b1; in_inst = 32'h0000_0000;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (illegal_cnt !== 2'd0) $display("FAIL midrst_cnt got=%0d exp=0", illegal_cnt); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%0b exp=0", in_ready); else passed++;
    total++; if (out_opcode !== 4'd0) $display("FAIL midrst_opcode got=%0d exp=0", out_opcode); else passed++;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sign_ext();
    test_mul();
    test_backpressure();
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
